// File: rtl/clkgate_pkg.sv
// Shared types for the multi-channel clock gate: channel FSM encoding and reset state.
`default_nettype none

package clkgate_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'd0,
    CG_ON   = 2'd1,
    CG_HOLD = 2'd2
  } cg_state_t;

  localparam cg_state_t CG_RST_STATE = CG_OFF;

endpackage : clkgate_pkg

`default_nettype wire

// File: rtl/clkgate_chan.sv
// One gated-clock channel: enable FSM with hold-off counter, enable register,
// low-transparent latch and AND gate.
`default_nettype none

module clkgate_chan
  import clkgate_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             E,
  input  logic             SE,
  input  logic [CNT_W-1:0] hold_i,
  output logic             GCK,
  output logic             off_o
);

  cg_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q;
  logic             latch_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_OFF: begin
        if (E) state_d = CG_ON;
      end
      CG_ON: begin
        if (!E) begin
          if (hold_i == '0) begin
            state_d = CG_OFF;
          end else begin
            state_d = CG_HOLD;
            cnt_d   = hold_i;
          end
        end
      end
      CG_HOLD: begin
        // A re-assertion on the expiry edge wins, so the clock never gaps.
        if (E) begin
          state_d = CG_ON;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = CG_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = CG_RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  assign off_o = (state_d == CG_OFF);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= CG_RST_STATE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != CG_OFF);
    end
  end

  // Latch closes while CK is high so enable changes cannot chop a pulse.
  always_latch begin
    if (!RN) begin
      latch_q <= 1'b0;
    end else if (!CK) begin
      latch_q <= en_q | SE;
    end
  end

  assign GCK = CK & latch_q;

endmodule : clkgate_chan

`default_nettype wire

// File: rtl/clkgate_multi_hold.sv
// NCH-channel clock gate with hold-off hysteresis, per-channel gated status
// and a registered count of open channels.
`default_nettype none

module clkgate_multi_hold
  import clkgate_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 4,
  localparam int ACT_W = $clog2(NCH + 1)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [NCH-1:0]   E,
  input  logic             SE,
  input  logic [CNT_W-1:0] hold_i,
  output logic [NCH-1:0]   GCK,
  output logic [NCH-1:0]   gated_o,
  output logic [ACT_W-1:0] act_cnt_o
);

  logic [NCH-1:0]   off_d;
  logic [NCH-1:0]   gated_q;
  logic [ACT_W-1:0] act_cnt_q, act_cnt_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clkgate_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .CK     (CK),
      .RN     (RN),
      .E      (E[i]),
      .SE     (SE),
      .hold_i (hold_i),
      .GCK    (GCK[i]),
      .off_o  (off_d[i])
    );
  end

  // gated_q mirrors each channel's current state, so the count lags it by one edge.
  always_comb begin
    act_cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      act_cnt_d = act_cnt_d + ACT_W'(!gated_q[i]);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      gated_q   <= '1;
      act_cnt_q <= '0;
    end else begin
      gated_q   <= off_d;
      act_cnt_q <= act_cnt_d;
    end
  end

  assign gated_o   = gated_q;
  assign act_cnt_o = act_cnt_q;

endmodule : clkgate_multi_hold

`default_nettype wire

// File: tb/tb_clkgate_multi_hold.sv
// Scoreboard bench for clkgate_multi_hold: expectations come from a timestamp
// model (last high sample plus captured hold) pushed at each drive.
`default_nettype none

module tb_clkgate_multi_hold;

  localparam int NCH   = 4;
  localparam int CNT_W = 4;
  localparam int ACT_W = 3;

  logic             CK = 1'b0;
  logic             RN = 1'b0;
  logic [NCH-1:0]   E = '0;
  logic             SE = 1'b0;
  logic [CNT_W-1:0] hold_i = '0;
  logic [NCH-1:0]   GCK;
  logic [NCH-1:0]   gated_o;
  logic [ACT_W-1:0] act_cnt_o;

  typedef struct {
    logic [NCH-1:0]   gck;
    logic [NCH-1:0]   gated;
    logic [ACT_W-1:0] act;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_high[NCH];
  int   hold_cap[NCH];

  clkgate_multi_hold #(
    .NCH   (NCH),
    .CNT_W (CNT_W)
  ) dut (
    .CK        (CK),
    .RN        (RN),
    .E         (E),
    .SE        (SE),
    .hold_i    (hold_i),
    .GCK       (GCK),
    .gated_o   (gated_o),
    .act_cnt_o (act_cnt_o)
  );

  always #5 CK = ~CK;

  // Channel is open after edge j if E was last seen high at m and j-m <= captured hold.
  function automatic bit open_after(int ch, int j);
    return (j - last_high[ch]) <= hold_cap[ch];
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      last_high[ch] = -1000;
      hold_cap[ch]  = 0;
    end
    sb.delete();
  endtask

  // Called with CK low; drives inputs for the coming posedge and queues its outcome.
  task automatic drive(input logic [NCH-1:0] e, input logic se, input logic [CNT_W-1:0] h);
    exp_t x;
    int   p;
    int   na;
    E = e; SE = se; hold_i = h;
    p  = cyc + 1;
    na = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      x.gck[ch] = se | open_after(ch, p - 1);
      if (open_after(ch, p - 1)) na++;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (e[ch]) last_high[ch] = p;
      else if (last_high[ch] == p - 1) hold_cap[ch] = int'(h);
      x.gated[ch] = !open_after(ch, p);
    end
    x.act = ACT_W'(na);
    cyc   = p;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    exp_t x;
    RN = 1'b0; E = '1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CK); #1;
      n_checks++;
      if (GCK !== '0 || gated_o !== 4'b1111 || act_cnt_o !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: GCK=%b gated=%b act=%0d, want 0000 1111 0", GCK, gated_o, act_cnt_o);
      end
    end
    @(negedge CK); #1;
    model_reset();
    RN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 1'b0, 4'd0);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL reset_release step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  task automatic test_holdoff();
    exp_t x;
    logic [NCH-1:0] e;
    for (int i = 0; i < 11; i++) begin
      e = '0; e[1] = (i < 5);
      drive(e, 1'b0, 4'd3);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL holdoff step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  // ch2 re-enables mid-HOLD; ch1 re-enables exactly on the expiry edge.
  task automatic test_back_to_back();
    exp_t x;
    logic [NCH-1:0] e;
    for (int i = 0; i < 14; i++) begin
      e = '0;
      e[2] = (i < 3) || (i >= 5 && i < 8);
      e[1] = (i < 2) || (i >= 5 && i < 7);
      drive(e, 1'b0, 4'd3);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  task automatic test_hold_zero();
    exp_t x;
    logic [NCH-1:0]   e;
    logic [CNT_W-1:0] h;
    for (int i = 0; i < 10; i++) begin
      e = '0; e[1] = (i < 2); e[3] = (i < 4);
      h = (i == 2) ? 4'd3 : (i == 4) ? 4'd0 : 4'd7;
      drive(e, 1'b0, h);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL hold_zero step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  task automatic test_se_override();
    exp_t x;
    for (int i = 0; i < 9; i++) begin
      drive('0, (i >= 4 && i < 7), 4'd0);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL se_override step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  task automatic test_max_hold();
    exp_t x;
    logic [NCH-1:0] e;
    for (int i = 0; i < 20; i++) begin
      e = '0; e[0] = (i < 2);
      drive(e, 1'b0, 4'd15);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL max_hold step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  task automatic test_random();
    exp_t x;
    for (int i = 0; i < 40; i++) begin
      drive(NCH'($urandom), ($urandom_range(0, 7) == 0), CNT_W'($urandom_range(0, 3)));
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL random step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  task automatic test_async_reset();
    exp_t x;
    logic [NCH-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive('1, 1'b0, 4'd2);
      @(posedge CK); #1;
      x = sb.pop_front();
      @(negedge CK); #1;
    end
    @(posedge CK); #2;
    n_checks++;
    if (GCK !== 4'b1111) begin
      n_fail++;
      $display("FAIL async_pre: GCK=%b, want 1111", GCK);
    end
    RN = 1'b0;
    #1;
    n_checks++;
    if (GCK !== '0 || gated_o !== 4'b1111 || act_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL async_assert: GCK=%b gated=%b act=%0d, want 0000 1111 0", GCK, gated_o, act_cnt_o);
    end
    E = '0;
    model_reset();
    @(negedge CK); #1;
    RN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = '0; e[2] = (i < 3);
      drive(e, 1'b0, 4'd1);
      @(posedge CK); #1;
      x = sb.pop_front();
      n_checks++;
      if (GCK !== x.gck || gated_o !== x.gated || act_cnt_o !== x.act) begin
        n_fail++;
        $display("FAIL async_restart step %0d: GCK=%b gated=%b act=%0d, want %b %b %0d",
                 i, GCK, gated_o, act_cnt_o, x.gck, x.gated, x.act);
      end
      @(negedge CK); #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_holdoff();
    test_back_to_back();
    test_hold_zero();
    test_se_override();
    test_max_hold();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_clkgate_multi_hold

`default_nettype wire

// File: doc/clkgate_multi_hold.md
Name: clkgate_multi_hold

Overview:
- Parametrised, multi-channel successor to the single test-enabled clock-gating cell.
- Each of NCH channels gates the common clock CK through a glitch-free low-transparent latch and AND.
- New relative to the single cell:
  - per-channel enable FSM with a programmable hold-off (hysteresis) counter, so short enable drops do not toggle the gate;
  - per-channel gated status outputs;
  - an open-channel count.
- Sits between the power-management controller (drives E) and the clock trees of NCH functional blocks.

Parameters:
- NCH, 4, number of gated channels (1..32).
- CNT_W, 4, width of the hold-off counter and hold_i.
- ACT_W, $clog2(NCH+1), width of act_cnt_o (derived, not overridable).

Ports:
- CK  input  1  free-running source clock.
- RN  input  1  asynchronous active-low reset.
- E  input  NCH  per-channel functional clock enable, synchronous to CK.
- SE  input  1  scan/test enable; forces all gates open.
- hold_i  input  CNT_W  number of extra open cycles after E falls; sampled on entry to HOLD.
- GCK  output  NCH  gated clocks.
- gated_o  output  NCH  1 = channel FSM in OFF (clock stopped functionally).
- act_cnt_o  output  ACT_W  registered count of channels whose FSM is not OFF.

Behaviour:
- Reset: RN low asynchronously forces the following, all immediately, independent of CK:
  - all FSMs to OFF; counters to 0;
  - enable regs en_q to 0 and gate latches to 0, so GCK = 0;
  - gated_o = all 1; act_cnt_o = 0.
  - Reset mid-pulse truncates a GCK high phase; this is accepted.
- Reset release: the first posedge of CK after RN rises is the first evaluating edge.
- Per-channel FSM, states OFF, ON, HOLD, evaluated at posedge CK:
  - OFF: E[i]=1 -> ON; else stay.
  - ON: E[i]=1 -> stay. E[i]=0 and hold_i==0 -> OFF. E[i]=0 and hold_i>0 -> HOLD with cnt=hold_i.
  - HOLD: E[i]=1 -> ON with cnt=0. Else cnt==1 -> OFF with cnt=0. Else cnt-=1.
  - hold_i changes while in HOLD are ignored until the next HOLD entry.
- Enable register: en_q[i] = (next state != OFF), registered at posedge CK.
- Gate latch: transparent while CK=0, captures (en_q[i] | SE). GCK[i] = CK & latch[i]. No glitches on GCK for any E/SE change timing that meets setup to posedge CK.
- Latency:
  - E[i] sampled high at posedge k produces the first GCK[i] pulse at posedge k+1.
  - E[i] sampled low at posedge k with hold_i=H gives the last GCK[i] pulse at posedge k+H. With H=0, posedge k is the last pulse.
- SE:
  - Bypasses the FSM. SE=1 while CK low opens all gates for the next high phase, the same timing as a plain ICG.
  - The FSM continues to follow E; gated_o and act_cnt_o reflect the FSM, not SE.
- gated_o[i] = (state==OFF), registered.
- act_cnt_o: popcount of (state != OFF), registered each posedge. Range 0..NCH. No overflow, because ACT_W is sized for NCH.
- Simultaneous events: E rising on the same edge the HOLD count expires -> ON wins; no GCK gap.
- Counter width: hold_i = 2^CNT_W-1 is legal. The counter never wraps.

Decomposition:
- Package clkgate_pkg:
  - typedef enum logic [1:0] {CG_OFF, CG_ON, CG_HOLD} cg_state_t;
  - localparam for the reset state.
- Sub-module clkgate_chan (one per channel, instantiated with generate):
  - contains the FSM, the hold counter, en_q, the latch and the AND;
  - ports CK, RN, E, SE, hold_i, GCK, off_o.
- The top level holds only the popcount register and the output registers.

Test Plan:
- Reset: hold RN=0 with CK toggling and E=all 1 -> GCK=0, gated_o=4'b1111, act_cnt_o=0. RN rises and E[0]=1 is sampled at posedge 1 -> first GCK[0] pulse at posedge 2; act_cnt_o=1 after posedge 2.
- Hold-off: hold_i=3, E[1] high for 5 cycles then low at posedge k -> GCK[1] pulses at k+1..k+3, none at k+4. gated_o[1] rises after posedge k+3.
- Re-enable in HOLD: hold_i=3, E[2] low for 2 cycles then high -> GCK[2] continuous with no missing pulse; FSM returns to ON; gated_o[2] stays 0.
- hold_i=0: E[3] drops at posedge k -> no GCK[3] pulse at k+1. hold_i changed to 7 mid-HOLD on another channel -> that channel closes per its old value.
- SE override: all E=0, FSMs OFF, SE=1 asserted while CK low -> all GCK toggle with CK on the next high phase; gated_o remains 4'b1111 and act_cnt_o=0. SE=0 -> gates close at the next CK low.
- Async reset mid-operation: all channels ON, RN pulsed low during CK high -> GCK drop to 0 immediately; after release all FSMs are OFF, then E restarts with 1-cycle latency.
